// File: rtl/gmii_rx_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_framer_pkg
//  Description : Shared SGMII receive definitions: framer FSM encoding,
//                CRC-32 constants and GMII preamble/SFD byte codes.
//  Revision    : 1.0  initial release
// ============================================================================
package gmii_rx_framer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } rxState_t;

   localparam logic [7:0]  c_BytePreamble = 8'h55;
   localparam logic [7:0]  c_ByteSfd      = 8'hD5;
   localparam logic [3:0]  c_PreambleMax  = 4'd15;

   // CRC constants in normal (MSB-first) bit order
   localparam logic [31:0] c_CrcPoly      = 32'h04C11DB7;
   localparam logic [31:0] c_CrcInit      = 32'hFFFFFFFF;
   localparam logic [31:0] c_CrcResidue   = 32'hC704DD7B;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   // The LSB-first shift register holds polynomial and residue bit-reversed
   localparam logic [31:0] c_CrcPolyRefl    = reflect32(c_CrcPoly);
   localparam logic [31:0] c_CrcResidueRefl = reflect32(c_CrcResidue);

endpackage
`default_nettype wire

// File: rtl/crc32_byte.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_byte
//  Description : Combinational byte-wide reflected CRC-32 next-state function
//                (one byte, LSB first).
//  Revision    : 1.0  initial release
// ============================================================================
module crc32_byte
   import gmii_rx_framer_pkg::*;
(
   input  logic [31:0] i_Crc,
   input  logic [7:0]  i8_Data,
   output logic [31:0] o_Crc
);

   logic [31:0] w_Crc;

   // Eight serial LFSR steps unrolled into one combinational stage
   always_comb begin
      w_Crc = i_Crc;
      for (int b = 0; b < 8; b++) begin
         w_Crc = (w_Crc >> 1) ^ ((w_Crc[0] ^ i8_Data[b]) ? c_CrcPolyRefl : 32'h0);
      end
      o_Crc = w_Crc;
   end

endmodule
`default_nettype wire

// File: rtl/gmii_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_framer
//  Description : GMII receive framer. Strips preamble/SFD/FCS, checks CRC,
//                length and code errors, and keeps good/bad frame counters.
//  Revision    : 1.0  initial release
// ============================================================================
module gmii_rx_framer
   import gmii_rx_framer_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
)
(
   input  logic        w_ClkSys,
   input  logic        i_ARstHardware_L,
   input  logic        i_Cke,
   input  logic [7:0]  i8_RxD,
   input  logic        i_RxDV,
   input  logic        i_RxER,
   output logic [7:0]  o8_Data,
   output logic        o_Valid,
   output logic        o_Sof,
   output logic        o_StatValid,
   output logic        o_CrcErr,
   output logic        o_LenErr,
   output logic        o_CodeErr,
   output logic [15:0] o16_GoodCnt,
   output logic [15:0] o16_BadCnt
);

   logic [1:0]       r_RstSync;
   logic             w_Rst_L;
   rxState_t         r_State, w_NextState;
   logic [3:0]       r_PreCnt;
   logic [3:0][7:0]  r_Dly;
   logic [2:0]       r_Fill;
   logic [31:0]      r_Crc, w_CrcNext;
   logic [11:0]      r_Len, w_LenNext;
   logic             r_CodeErr, r_LenErr, r_FromData, r_SofPend;
   logic             r_Valid, r_Sof, r_StatValid;
   logic [7:0]       r_Data;
   logic             r_OutCrc, r_OutLen, r_OutCode;
   logic [15:0]      r_GoodCnt, r_BadCnt;
   logic             w_FrameStart, w_EnterData, w_PreStart, w_PreInc;
   logic             w_Shift, w_Emit, w_Overflow;
   logic             w_Stat, w_StatCrc, w_StatLen, w_StatCode;

   // Reset asserts immediately, releases on the second clock edge
   always_ff @(posedge w_ClkSys or negedge i_ARstHardware_L) begin
      if (!i_ARstHardware_L) r_RstSync <= 2'b00;
      else                   r_RstSync <= {r_RstSync[0], 1'b1};
   end
   assign w_Rst_L = r_RstSync[1];

   crc32_byte u_Crc (
      .i_Crc   (r_Crc),
      .i8_Data (i8_RxD),
      .o_Crc   (w_CrcNext)
   );

   // FSM state register, advancing only on sampled bytes
   always_ff @(posedge w_ClkSys or negedge w_Rst_L) begin
      if (!w_Rst_L)   r_State <= ST_IDLE;
      else if (i_Cke) r_State <= w_NextState;
   end

   // Next-state decode and per-byte action strobes
   always_comb begin
      w_NextState  = r_State;
      w_FrameStart = 1'b0;
      w_EnterData  = 1'b0;
      w_PreStart   = 1'b0;
      w_PreInc     = 1'b0;
      w_Shift      = 1'b0;
      w_Emit       = 1'b0;
      w_Overflow   = 1'b0;
      w_Stat       = 1'b0;
      w_StatCrc    = 1'b0;
      w_StatLen    = 1'b0;
      w_StatCode   = 1'b0;
      w_LenNext    = (r_Len == 12'hFFF) ? r_Len : r_Len + 12'd1;
      case (r_State)
         ST_IDLE: begin
            if (i_RxDV) begin
               w_FrameStart = 1'b1;
               if (i8_RxD == c_BytePreamble) begin
                  w_NextState = ST_PREAMBLE;
                  w_PreStart  = 1'b1;
               end else if (i8_RxD == c_ByteSfd) begin
                  w_NextState = ST_DATA;
                  w_EnterData = 1'b1;
               end else begin
                  w_NextState = ST_DROP;
               end
            end
         end
         ST_PREAMBLE: begin
            if (!i_RxDV) begin
               w_NextState = ST_IDLE;
            end else if (i8_RxD == c_BytePreamble) begin
               if (r_PreCnt == c_PreambleMax) w_NextState = ST_DROP;
               else                           w_PreInc    = 1'b1;
            end else if (i8_RxD == c_ByteSfd) begin
               w_NextState = ST_DATA;
               w_EnterData = 1'b1;
            end else begin
               w_NextState = ST_DROP;
            end
         end
         ST_DATA: begin
            if (i_RxDV) begin
               w_Shift = 1'b1;
               if (int'(w_LenNext) == MAX_LEN + 1) begin
                  w_Overflow  = 1'b1;
                  w_NextState = ST_DROP;
               end else begin
                  w_Emit = (r_Fill == 3'd4);
               end
            end else begin
               w_NextState = ST_IDLE;
               w_Stat      = 1'b1;
               w_StatCrc   = (r_Crc != c_CrcResidueRefl);
               w_StatLen   = r_LenErr || (int'(r_Len) < MIN_LEN) || (int'(r_Len) > MAX_LEN);
               w_StatCode  = r_CodeErr;
            end
         end
         ST_DROP: begin
            if (!i_RxDV) begin
               w_NextState = ST_IDLE;
               // Oversized frames report length/code only; their CRC was cut short
               w_Stat      = r_FromData;
               w_StatLen   = r_LenErr;
               w_StatCode  = r_CodeErr;
            end
         end
         default: w_NextState = ST_IDLE;
      endcase
   end

   // Delay line, CRC, length, flags, output registers and frame counters
   always_ff @(posedge w_ClkSys or negedge w_Rst_L) begin
      if (!w_Rst_L) begin
         r_PreCnt    <= '0;
         r_Dly       <= '0;
         r_Fill      <= '0;
         r_Crc       <= c_CrcInit;
         r_Len       <= '0;
         r_CodeErr   <= 1'b0;
         r_LenErr    <= 1'b0;
         r_FromData  <= 1'b0;
         r_SofPend   <= 1'b0;
         r_Valid     <= 1'b0;
         r_Sof       <= 1'b0;
         r_Data      <= '0;
         r_StatValid <= 1'b0;
         r_OutCrc    <= 1'b0;
         r_OutLen    <= 1'b0;
         r_OutCode   <= 1'b0;
         r_GoodCnt   <= '0;
         r_BadCnt    <= '0;
      end else if (i_Cke) begin
         r_Valid     <= w_Emit;
         r_Sof       <= w_Emit && r_SofPend;
         r_StatValid <= w_Stat;
         if (w_Emit) begin
            r_Data    <= r_Dly[3];
            r_SofPend <= 1'b0;
         end
         if (w_PreStart) r_PreCnt <= 4'd1;
         if (w_PreInc)   r_PreCnt <= r_PreCnt + 4'd1;
         if (w_FrameStart) begin
            r_CodeErr  <= 1'b0;
            r_LenErr   <= 1'b0;
            r_FromData <= 1'b0;
            r_OutCrc   <= 1'b0;
            r_OutLen   <= 1'b0;
            r_OutCode  <= 1'b0;
         end
         if (w_EnterData) begin
            r_Crc     <= c_CrcInit;
            r_Len     <= '0;
            r_Fill    <= '0;
            r_SofPend <= 1'b1;
         end
         if (w_Shift) begin
            r_Dly <= {r_Dly[2:0], i8_RxD};
            r_Crc <= w_CrcNext;
            r_Len <= w_LenNext;
            if (r_Fill != 3'd4) r_Fill    <= r_Fill + 3'd1;
            if (i_RxER)         r_CodeErr <= 1'b1;
            if (w_Overflow) begin
               r_LenErr   <= 1'b1;
               r_FromData <= 1'b1;
            end
         end
         if (w_Stat) begin
            r_OutCrc  <= w_StatCrc;
            r_OutLen  <= w_StatLen;
            r_OutCode <= w_StatCode;
         end
         if (r_StatValid) begin
            if (!r_OutCrc && !r_OutLen && !r_OutCode) begin
               if (r_GoodCnt != 16'hFFFF) r_GoodCnt <= r_GoodCnt + 16'd1;
            end else begin
               if (r_BadCnt != 16'hFFFF)  r_BadCnt  <= r_BadCnt + 16'd1;
            end
         end
      end
   end

   // Strobes are visible only on sampled cycles so each shows exactly once
   assign o_Valid     = r_Valid && i_Cke;
   assign o_Sof       = r_Sof && i_Cke;
   assign o_StatValid = r_StatValid && i_Cke;
   assign o8_Data     = r_Data;
   assign o_CrcErr    = r_OutCrc;
   assign o_LenErr    = r_OutLen;
   assign o_CodeErr   = r_OutCode;
   assign o16_GoodCnt = r_GoodCnt;
   assign o16_BadCnt  = r_BadCnt;

endmodule
`default_nettype wire
